// File: rtl/adiabatic_pkg.sv
// Shared phase encoding and per-stage phase decode for the adiabatic pipeline.
package adiabatic_pkg;

    localparam int PH_COUNT = 4;

    typedef enum logic [1:0] {
        PH_WAIT    = 2'd0,
        PH_EVAL    = 2'd1,
        PH_HOLD    = 2'd2,
        PH_RECOVER = 2'd3
    } phase_t;

    // Each stage lags the global power clock by one quarter-phase per stage index.
    function automatic phase_t stage_phase(input logic [1:0] ph, input int unsigned k);
        logic [1:0] k_mod;
        k_mod = k[1:0];
        return phase_t'(ph - k_mod);
    endfunction

endpackage

// File: rtl/adiabatic_buf_stage.sv
// Clocked adiabatic buffer: captures the upstream token during its EVAL phase.
module adiabatic_buf_stage import adiabatic_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic             clkpos,
    input  logic             rst,
    input  logic             en,
    input  phase_t           phase,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] d_q;
    logic             v_q;

    // Data is retained through RECOVER/WAIT until the next EVAL overwrites it.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else if (en && phase == PH_EVAL) begin
            d_q <= d_in;
            v_q <= v_in;
        end
    end

    assign d_out = d_q;
    assign v_out = v_q;

endmodule

// File: rtl/adiabatic_nandn_pipe.sv
// Four-phase adiabatic pipeline: N_IN-input NAND/AND gate stage followed by
// STAGES-1 buffer stages, with a saturating completed-token counter.
module adiabatic_nandn_pipe import adiabatic_pkg::*; #(
    parameter int N_IN   = 2,
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clkpos,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*N_IN-1:0] a,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    input  logic                  clr_count,
    output logic [CNT_W-1:0]      op_count
);

    localparam int LAST = STAGES - 1;

    logic [1:0] ph_q, ph_d;
    phase_t     stg_ph [STAGES];

    logic [STAGES-1:0][WIDTH-1:0] d_stg;
    logic [STAGES-1:0]            v_stg;

    logic [WIDTH-1:0] gate_w;
    logic [WIDTH-1:0] d0_q;
    logic             v0_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_hold;
    logic             cnt_inc;

    assign ph_d = ph_q + 2'd1;

    always_ff @(posedge clkpos or posedge rst) begin
        if (rst)     ph_q <= 2'd0;
        else if (en) ph_q <= ph_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_ph
        assign stg_ph[k] = stage_phase(ph_q, k);
    end

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        assign gate_w[l] = mode ? (&a[l*N_IN +: N_IN]) : ~(&a[l*N_IN +: N_IN]);
    end

    // A bubble clears the data as well so idle slots never carry stale lanes.
    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            d0_q <= '0;
            v0_q <= 1'b0;
        end else if (en && stg_ph[0] == PH_EVAL) begin
            d0_q <= in_valid ? gate_w : '0;
            v0_q <= in_valid;
        end
    end

    assign d_stg[0] = d0_q;
    assign v_stg[0] = v0_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        adiabatic_buf_stage #(.WIDTH(WIDTH)) u_stage (
            .clkpos (clkpos),
            .rst    (rst),
            .en     (en),
            .phase  (stg_ph[k]),
            .d_in   (d_stg[k-1]),
            .v_in   (v_stg[k-1]),
            .d_out  (d_stg[k]),
            .v_out  (v_stg[k])
        );
    end

    assign last_hold = (stg_ph[LAST] == PH_HOLD);
    assign in_ready  = en && (stg_ph[0] == PH_EVAL);
    assign out       = last_hold ? d_stg[LAST] : '0;
    assign out_valid = last_hold && v_stg[LAST];

    // A token counts when the last stage leaves HOLD; clear beats increment.
    assign cnt_inc = en && last_hold && v_stg[LAST];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count)
            cnt_d = '0;
        else if (cnt_inc && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;

endmodule

// File: tb/tb_adiabatic_nandn_pipe.sv
// Directed bench: three pipeline variants (default, 2-bit counter, 5 stages) share stimulus.
module tb_adiabatic_nandn_pipe;

    logic       clkpos = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr_count = 1'b0;
    logic [7:0] a = '0;

    logic        rdy0, ov0, rdy1, ov1, rdy2, ov2;
    logic [3:0]  out0, out1, out2;
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clkpos = ~clkpos;

    adiabatic_nandn_pipe #(.N_IN(2), .WIDTH(4), .STAGES(2), .CNT_W(16)) u_dut0 (
        .clkpos(clkpos), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy0), .a(a), .out(out0), .out_valid(ov0),
        .clr_count(clr_count), .op_count(cnt0));

    adiabatic_nandn_pipe #(.N_IN(2), .WIDTH(4), .STAGES(2), .CNT_W(2)) u_dut1 (
        .clkpos(clkpos), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy1), .a(a), .out(out1), .out_valid(ov1),
        .clr_count(clr_count), .op_count(cnt1));

    adiabatic_nandn_pipe #(.N_IN(2), .WIDTH(4), .STAGES(5), .CNT_W(16)) u_dut2 (
        .clkpos(clkpos), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy2), .a(a), .out(out2), .out_valid(ov2),
        .clr_count(clr_count), .op_count(cnt2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkpos);
        #1;
    endtask

    initial begin
        int acc, pulses, last_p, gap_bad, stall_bad;

        // reset state, with en high so in_ready depends only on ph
        en = 1'b1;
        a = 8'b11_10_01_00;
        in_valid = 1'b1;
        #1;
        check("rst_out", 64'(out0), 64'h0);
        check("rst_ov", 64'(ov0), 64'h0);
        check("rst_cnt", 64'(cnt0), 64'h0);
        check("rst_rdy", 64'(rdy0), 64'h0);
        tick();
        check("rst_hold_rdy", 64'(rdy0), 64'h0);
        rst = 1'b0;

        // NAND basic
        tick();                                    // ph=1
        check("nand_rdy", 64'(rdy0), 64'h1);
        check("nand_out_eval", 64'(out0), 64'h0);
        tick();                                    // accepted, ph=2
        check("nand_ov_early", 64'(ov0), 64'h0);
        tick();                                    // ph=3
        check("nand_out", 64'(out0), 64'h7);
        check("nand_ov", 64'(ov0), 64'h1);
        check("nand_ov_cnt2", 64'(ov1), 64'h1);
        mode = 1'b1;
        tick();                                    // ph=0
        check("nand_out_after", 64'(out0), 64'h0);
        check("nand_ov_after", 64'(ov0), 64'h0);
        check("nand_cnt", 64'(cnt0), 64'h1);

        // AND mode
        tick();
        tick();
        tick();                                    // ph=3
        check("and_out", 64'(out0), 64'h8);
        check("and_ov", 64'(ov0), 64'h1);
        tick();
        check("and_cnt", 64'(cnt0), 64'h2);
        check("and_cnt_c2", 64'(cnt1), 64'h2);

        // throughput: 12 cycles of continuous in_valid
        acc = 0; pulses = 0; last_p = -1; gap_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (rdy0 && in_valid) acc++;
            if (ov0) begin
                if (last_p >= 0 && i - last_p != 4) gap_bad++;
                last_p = i;
                pulses++;
            end
            tick();
        end
        check("thr_accepted", 64'(acc), 64'd3);
        check("thr_pulses", 64'(pulses), 64'd3);
        check("thr_gap", 64'(gap_bad), 64'd0);
        check("thr_cnt", 64'(cnt0), 64'd5);
        check("sat_cnt", 64'(cnt1), 64'd3);

        // bubble
        in_valid = 1'b0;
        tick();                                    // ph=1
        tick();                                    // bubble captured
        in_valid = 1'b1;
        tick();                                    // ph=3
        check("bub_ov", 64'(ov0), 64'h0);
        check("bub_out", 64'(out0), 64'h0);
        tick();
        check("bub_cnt", 64'(cnt0), 64'd5);

        // stall while the token sits in stage 0 HOLD
        mode = 1'b0;
        a = 8'b01_11_11_00;
        tick();                                    // ph=1
        tick();                                    // accepted, ph=2
        en = 1'b0;
        a = 8'h00;
        mode = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ov0 !== 1'b0 || out0 !== 4'h0 || rdy0 !== 1'b0) stall_bad++;
        end
        check("stall_frozen", 64'(stall_bad), 64'd0);
        en = 1'b1;
        a = 8'b01_11_11_00;
        mode = 1'b0;
        tick();                                    // ph=3
        check("stall_ov", 64'(ov0), 64'h1);
        check("stall_out", 64'(out0), 64'h9);
        tick();
        check("stall_cnt", 64'(cnt0), 64'd6);
        check("stall_sat", 64'(cnt1), 64'd3);

        // clear on the same edge as an increment
        tick();
        tick();
        tick();                                    // ph=3
        check("clr_ov", 64'(ov0), 64'h1);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_cnt", 64'(cnt0), 64'd0);
        check("clr_cnt_c2", 64'(cnt1), 64'd0);

        // reset while the token is held in stage 1
        tick();
        tick();
        tick();                                    // ph=3
        check("mid_ov", 64'(ov0), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", 64'(out0), 64'h0);
        check("mid_rst_ov", 64'(ov0), 64'h0);
        check("mid_rst_cnt", 64'(cnt0), 64'h0);
        check("mid_rst_rdy", 64'(rdy0), 64'h0);
        check("mid_rst_cnt5", 64'(cnt2), 64'h0);
        tick();
        rst = 1'b0;
        tick();                                    // ph=1
        check("post_rdy", 64'(rdy0), 64'h1);
        check("post_rdy5", 64'(rdy2), 64'h1);
        tick();                                    // accepted, cycle t+1
        check("post_ov_t1", 64'(ov0), 64'h0);
        check("post_ov5_t1", 64'(ov2), 64'h0);
        tick();                                    // t+2
        check("post_out", 64'(out0), 64'h9);
        check("post_ov", 64'(ov0), 64'h1);
        tick();                                    // t+3
        check("post_cnt", 64'(cnt0), 64'd1);
        tick();                                    // t+4
        check("post_ov5_t4", 64'(ov2), 64'h0);
        tick();                                    // t+5
        check("post_ov5", 64'(ov2), 64'h1);
        check("post_out5", 64'(out2), 64'h9);
        tick();
        check("post_cnt5", 64'(cnt2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
